// File: rtl/cactus_scheduler.sv
// cactus_scheduler: paces obstacle spawns for the dino game.
// Counts frame ticks down from a gap, stirs the cactus LFSR for a fixed
// number of cycles, samples it to pick the obstacle kind and the next gap,
// then offers the obstacle to the renderer.
//
// Handshake: spawn_valid rises only in OFFER and, once high, stays high with
// spawn_kind frozen until a clock edge where spawn_valid & spawn_ready are
// both high (the transfer). The first valid cycle may transfer. The only way
// valid drops without a transfer is enable going low (or reset), which
// discards the offer.
//
// Reset asserts asynchronously; its release is expected to arrive already
// aligned to clk from the reset generator.
module cactus_scheduler #(
  parameter int MIN_GAP     = 16,
  parameter int STIR_CYCLES = 3,
  parameter int GAP_BITS    = 8
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic                tick,
  input  logic [1:0]          level,
  input  logic [4:0]          rng_value,
  output logic                rng_step,
  output logic                spawn_valid,
  input  logic                spawn_ready,
  output logic [1:0]          spawn_kind,
  output logic [GAP_BITS-1:0] gap_cnt,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_STIR  = 3'd2,
    S_DRAW  = 3'd3,
    S_OFFER = 3'd4
  } state_t;

  localparam int STIR_W = (STIR_CYCLES > 1) ? $clog2(STIR_CYCLES) : 1;
  localparam logic [STIR_W-1:0]   STIR_LAST = STIR_W'(STIR_CYCLES - 1);
  localparam logic [GAP_BITS-1:0] MIN_GAP_V = GAP_BITS'(MIN_GAP);
  localparam logic [31:0]         GAP_MAX   = 32'((64'd1 << GAP_BITS) - 64'd1);

  state_t              state_q, state_d;
  logic [STIR_W-1:0]   stir_q, stir_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic [GAP_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          kind_q, kind_d;
  logic                valid_q, valid_d;
  logic                step_q, step_d;

  logic [6:0]          scaled;
  logic [31:0]         gap_sum;
  logic [GAP_BITS-1:0] gap_sat;

  // Candidate gap from the current LFSR sample: lower levels spread gaps wider.
  always_comb begin
    scaled  = {3'b000, rng_value[3:0]} << (2'd3 - level);
    gap_sum = 32'(MIN_GAP) + 32'(scaled);
    gap_sat = (gap_sum > GAP_MAX) ? GAP_BITS'(GAP_MAX) : gap_sum[GAP_BITS-1:0];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    stir_d  = stir_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    valid_d = valid_q;
    step_d  = step_q;
    if (!enable) begin
      // Abort from any state: drop any pending offer, rearm the first gap.
      state_d = S_IDLE;
      step_d  = 1'b0;
      valid_d = 1'b0;
      stir_d  = '0;
      cnt_d   = MIN_GAP_V;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COUNT;
          cnt_d   = MIN_GAP_V;
        end
        S_COUNT: begin
          if (tick) begin
            if (cnt_q == GAP_BITS'(1)) begin
              state_d = S_STIR;
              step_d  = 1'b1;
              stir_d  = '0;
            end else begin
              cnt_d = cnt_q - GAP_BITS'(1);
            end
          end
        end
        S_STIR: begin
          if (stir_q == STIR_LAST) begin
            state_d = S_DRAW;
            step_d  = 1'b0;
            stir_d  = '0;
          end else begin
            stir_d = stir_q + STIR_W'(1);
          end
        end
        S_DRAW: begin
          // An all-zero LFSR is a locked-up state; fall back to a plain spawn.
          if (rng_value == 5'd0) begin
            kind_d = 2'b00;
            gap_d  = MIN_GAP_V;
          end else begin
            kind_d = {rng_value[4], rng_value[0]};
            gap_d  = gap_sat;
          end
          valid_d = 1'b1;
          state_d = S_OFFER;
        end
        S_OFFER: begin
          if (valid_q && spawn_ready) begin
            valid_d = 1'b0;
            cnt_d   = gap_q;
            state_d = S_COUNT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      stir_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= MIN_GAP_V;
      kind_q  <= 2'b00;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stir_q  <= stir_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      valid_q <= valid_d;
      step_q  <= step_d;
    end
  end

  assign rng_step    = step_q;
  assign spawn_valid = valid_q;
  assign spawn_kind  = kind_q;
  assign gap_cnt     = cnt_q;
  assign fsm_state   = state_q;

endmodule
